ddr_burst_arbiter: RTL and testbench

Shares the single DDR command port among three burst requesters: camera-0 frame writer, camera-1 frame writer and the HDMI frame reader. Sits between the per-camera write FIFOs / display read FIFO and the DDR memory-interface user port, inside the dual-camera graphics pipeline. Grants one fixed-length burst at a time. Display reads get priority; writers are served round-robin with anti-starvation promotion. Camera enables from the Cortex-M3 GPIO mask the writers.

---
 rtl/ddr_burst_arbiter_pkg.sv | 24 ++
 rtl/ddr_arb_pick.sv | 40 ++++
 rtl/ddr_burst_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared encodings for the dual-camera pipeline DDR arbiter: command source
// codes that steer the data-path muxes, and the arbiter state machine states.
package ddr_burst_arbiter_pkg;

    localparam logic [1:0] SRC_WR0 = 2'd0;
    localparam logic [1:0] SRC_WR1 = 2'd1;
    localparam logic [1:0] SRC_RD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

    // Choice vector layout: bit0 = wr0, bit1 = wr1, bit2 = rd.
    function automatic logic [1:0] onehot_to_src(input logic [2:0] oh);
        logic [1:0] src;
        src = SRC_WR0;
        if (oh[1]) src = SRC_WR1;
        if (oh[2]) src = SRC_RD;
        return src;
    endfunction

endpackage

// File: rtl/ddr_arb_pick.sv
// Combinational burst selector: starving writers first, then the display
// reader, then the writers in round-robin order. Returns a one-hot choice.
module ddr_arb_pick
    import ddr_burst_arbiter_pkg::*;
(
    input  logic       e0_i,
    input  logic       e1_i,
    input  logic       er_i,
    input  logic       starve0_i,
    input  logic       starve1_i,
    input  logic       rr_wr1_i,
    output logic [2:0] pick_o
);

    logic s0;
    logic s1;

    assign s0 = e0_i & starve0_i;
    assign s1 = e1_i & starve1_i;

    always_comb begin
        pick_o = '0;
        if (s0 && s1) begin
            pick_o = rr_wr1_i ? 3'b010 : 3'b001;
        end else if (s0) begin
            pick_o = 3'b001;
        end else if (s1) begin
            pick_o = 3'b010;
        end else if (er_i) begin
            pick_o = 3'b100;
        end else if (e0_i && e1_i) begin
            pick_o = rr_wr1_i ? 3'b010 : 3'b001;
        end else if (e0_i) begin
            pick_o = 3'b001;
        end else if (e1_i) begin
            pick_o = 3'b010;
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Shares the DDR user command port between two camera frame writers and the
// HDMI frame reader, one fixed-length burst at a time.
module ddr_burst_arbiter
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned STARVE_MAX = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmos0_en,
    input  logic              cmos1_en,
    input  logic              wr0_req,
    input  logic              wr1_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              wr0_grant,
    output logic              wr1_grant,
    output logic              rd_grant,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [1:0]        cmd_src,
    input  logic              beat_valid,
    output logic              burst_done,
    output logic              busy
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int unsigned WAIT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [1:0]        cmd_src_q, cmd_src_d;
    logic [2:0]        grant_q, grant_d;
    logic              done_q, done_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              rr_q, rr_d;
    logic [WAIT_W-1:0] wait_q [2];
    logic [WAIT_W-1:0] wait_d [2];

    logic [1:0] eff;
    logic [1:0] starve;
    logic [1:0] active;
    logic [1:0] granted;
    logic [2:0] pick;

    assign eff[0] = wr0_req & cmos0_en;
    assign eff[1] = wr1_req & cmos1_en;

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            starve[i]  = (wait_q[i] >= WAIT_W'(STARVE_MAX));
            active[i]  = (state_q != ST_IDLE) && (cmd_src_q == 2'(i));
            granted[i] = (state_q == ST_CMD) && cmd_ready && (cmd_src_q == 2'(i));
        end
    end

    ddr_arb_pick u_pick (
        .e0_i      (eff[0]),
        .e1_i      (eff[1]),
        .er_i      (rd_req),
        .starve0_i (starve[0]),
        .starve1_i (starve[1]),
        .rr_wr1_i  (rr_q),
        .pick_o    (pick)
    );

    always_comb begin
        state_d    = state_q;
        cmd_addr_d = cmd_addr_q;
        cmd_wr_d   = cmd_wr_q;
        cmd_src_d  = cmd_src_q;
        grant_d    = '0;
        done_d     = 1'b0;
        beat_d     = beat_q;
        rr_d       = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    state_d    = ST_CMD;
                    cmd_src_d  = onehot_to_src(pick);
                    cmd_wr_d   = ~pick[2];
                    cmd_addr_d = pick[0] ? wr0_addr : (pick[1] ? wr1_addr : rd_addr);
                end
            end
            ST_CMD: begin
                if (cmd_ready) begin
                    grant_d = {cmd_src_q == SRC_RD, cmd_src_q == SRC_WR1, cmd_src_q == SRC_WR0};
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_d == BEAT_W'(BURST_LEN)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        // Hand the round-robin preference to the writer that did not just run.
                        if (cmd_wr_q) rr_d = (cmd_src_q == SRC_WR0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            wait_d[i] = wait_q[i];
            if (!eff[i] || granted[i]) begin
                wait_d[i] = '0;
            end else if (!active[i] && !starve[i]) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cmd_addr_q <= '0;
            cmd_wr_q   <= 1'b0;
            cmd_src_q  <= SRC_WR0;
            grant_q    <= '0;
            done_q     <= 1'b0;
            beat_q     <= '0;
            rr_q       <= 1'b0;
            wait_q[0]  <= '0;
            wait_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_src_q  <= cmd_src_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            beat_q     <= beat_d;
            rr_q       <= rr_d;
            wait_q[0]  <= wait_d[0];
            wait_q[1]  <= wait_d[1];
        end
    end

    assign cmd_valid  = (state_q == ST_CMD);
    assign busy       = (state_q != ST_IDLE);
    assign cmd_addr   = cmd_addr_q;
    assign cmd_wr     = cmd_wr_q;
    assign cmd_src    = cmd_src_q;
    assign wr0_grant  = grant_q[0];
    assign wr1_grant  = grant_q[1];
    assign rd_grant   = grant_q[2];
    assign burst_done = done_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter with default parameters
// (ADDR_W 28, BURST_LEN 64, STARVE_MAX 255).
module tb_ddr_burst_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        cmos0_en, cmos1_en;
    logic        wr0_req, wr1_req, rd_req;
    logic [27:0] wr0_addr, wr1_addr, rd_addr;
    logic        wr0_grant, wr1_grant, rd_grant;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [27:0] cmd_addr;
    logic [1:0]  cmd_src;
    logic        beat_valid, burst_done, busy;
    logic [2:0]  gnt;

    int ntests = 0;
    int nfail  = 0;

    always #5 sys_clk = ~sys_clk;
    assign gnt = {rd_grant, wr1_grant, wr0_grant};

    ddr_burst_arbiter #(.ADDR_W(28), .BURST_LEN(64), .STARVE_MAX(255)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cmos0_en   (cmos0_en),
        .cmos1_en   (cmos1_en),
        .wr0_req    (wr0_req),
        .wr1_req    (wr1_req),
        .rd_req     (rd_req),
        .wr0_addr   (wr0_addr),
        .wr1_addr   (wr1_addr),
        .rd_addr    (rd_addr),
        .wr0_grant  (wr0_grant),
        .wr1_grant  (wr1_grant),
        .rd_grant   (rd_grant),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_src    (cmd_src),
        .beat_valid (beat_valid),
        .burst_done (burst_done),
        .busy       (busy)
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beats(input int n);
        beat_valid = 1'b1;
        repeat (n) tick;
        beat_valid = 1'b0;
    endtask

    task automatic wait_grant(output logic [2:0] g);
        g = '0;
        for (int i = 0; i < 20 && g == 3'b000; i++) begin
            tick;
            g = gnt;
        end
        if (g == 3'b000) begin
            ntests++;
            nfail++;
            $error("FAIL grant_timeout observed=none expected=grant within 20 cycles");
        end
    endtask

    initial begin
        logic [2:0] g;
        logic [2:0] exp_oh;
        int         exp_src [11];
        exp_src = '{2, 2, 2, 2, 0, 1, 2, 2, 2, 0, 1};

        sys_rst_n = 1'b0;
        cmos0_en = 1'b0; cmos1_en = 1'b0;
        wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
        wr0_addr = '0; wr1_addr = '0; rd_addr = '0;
        cmd_ready = 1'b0; beat_valid = 1'b0;
        #23;
        check("rst_ctrl", {27'd0, gnt, burst_done, cmd_valid}, 32'd0);
        check("rst_busy_wr", {30'd0, busy, cmd_wr}, 32'd0);
        check("rst_addr", {4'd0, cmd_addr}, 32'd0);
        check("rst_src", {30'd0, cmd_src}, 32'd0);
        sys_rst_n = 1'b1;
        tick; tick;

        // Single reader burst
        rd_req = 1'b1; rd_addr = 28'h100; cmd_ready = 1'b1;
        tick;
        check("rd_cmd", {cmd_valid, cmd_wr, cmd_src, busy, gnt}, {1'b1, 1'b0, 2'd2, 1'b1, 3'b000});
        check("rd_addr", {4'd0, cmd_addr}, 32'h100);
        tick;
        check("rd_grant", {cmd_valid, gnt}, {1'b0, 3'b100});
        rd_req = 1'b0;
        beat_valid = 1'b1;
        repeat (63) tick;
        check("rd_beat63", {burst_done, busy}, 2'b01);
        tick;
        check("rd_beat64", {burst_done, busy}, 2'b10);
        beat_valid = 1'b0;
        tick;
        check("rd_after", {burst_done, cmd_valid, busy}, 3'b000);

        // cmd_ready held low: command must hold steady without a grant
        cmd_ready = 1'b0; rd_req = 1'b1; rd_addr = 28'h2A0;
        tick;
        for (int i = 0; i < 10; i++) begin
            check("hold", {cmd_valid, gnt, cmd_addr}, {1'b1, 3'b000, 28'h2A0});
            tick;
        end
        cmd_ready = 1'b1;
        tick;
        check("hold_grant", {29'd0, gnt}, 32'b100);
        rd_req = 1'b0;
        beats(64);
        check("hold_done", {31'd0, burst_done}, 32'd1);
        tick;

        // Masked writer 1
        wr1_req = 1'b1; wr1_addr = 28'h4000; cmos1_en = 1'b0;
        repeat (5) begin
            tick;
            check("wr1_masked", {30'd0, busy, cmd_valid}, 32'd0);
        end
        cmos1_en = 1'b1;
        tick;
        check("wr1_cmd", {cmd_valid, cmd_wr, cmd_src, cmd_addr}, {1'b1, 1'b1, 2'd1, 28'h4000});
        tick;
        check("wr1_grant", {29'd0, gnt}, 32'b010);
        wr1_req = 1'b0;
        beats(64);
        check("wr1_done", {31'd0, burst_done}, 32'd1);
        tick;

        // Writer 0 enable dropped mid-burst
        cmos0_en = 1'b1; wr0_req = 1'b1; wr0_addr = 28'h8000;
        tick;
        check("wr0_cmd", {cmd_valid, cmd_wr, cmd_src, cmd_addr}, {1'b1, 1'b1, 2'd0, 28'h8000});
        tick;
        check("wr0_grant", {29'd0, gnt}, 32'b001);
        beat_valid = 1'b1;
        repeat (30) tick;
        cmos0_en = 1'b0;
        repeat (33) tick;
        check("wr0_beat63", {burst_done, busy}, 2'b01);
        tick;
        check("wr0_beat64", {burst_done, busy}, 2'b10);
        beat_valid = 1'b0;
        repeat (4) begin
            tick;
            check("wr0_masked", {30'd0, busy, cmd_valid}, 32'd0);
        end
        wr0_req = 1'b0; cmos0_en = 1'b1;

        // Reset asserted mid-burst
        rd_req = 1'b1; rd_addr = 28'h300;
        tick; tick;
        check("rst_mid_grant", {29'd0, gnt}, 32'b100);
        rd_req = 1'b0;
        beat_valid = 1'b1;
        repeat (20) tick;
        check("pre_rst", {busy, cmd_src, cmd_addr}, {1'b1, 2'd2, 28'h300});
        sys_rst_n = 1'b0;
        #1;
        check("async_rst", {busy, cmd_src, cmd_addr}, 31'd0);
        check("async_rst_ctrl", {27'd0, gnt, burst_done, cmd_valid}, 32'd0);
        beat_valid = 1'b0;
        tick;
        sys_rst_n = 1'b1;
        tick;
        rd_req = 1'b1; rd_addr = 28'h340;
        tick;
        check("post_rst_cmd", {cmd_valid, cmd_src, cmd_addr}, {1'b1, 2'd2, 28'h340});
        tick;
        check("post_rst_grant", {29'd0, gnt}, 32'b100);
        rd_req = 1'b0;
        beat_valid = 1'b1;
        repeat (63) tick;
        check("post_rst_beat63", {31'd0, burst_done}, 32'd0);
        tick;
        check("post_rst_beat64", {31'd0, burst_done}, 32'd1);
        beat_valid = 1'b0;
        tick;

        // All three requesting: reader until writers starve, then wr0, wr1
        wr0_addr = 28'h1000; wr1_addr = 28'h2000; rd_addr = 28'h3000;
        cmos0_en = 1'b1; cmos1_en = 1'b1;
        wr0_req = 1'b1; wr1_req = 1'b1; rd_req = 1'b1; cmd_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wait_grant(g);
            exp_oh = 3'b001 << exp_src[i];
            check($sformatf("order%0d", i), {29'd0, g}, {29'd0, exp_oh});
            beats(64);
        end
        wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
